// File: rtl/sobel_frame_ctrl_pkg.sv
// Shared constants for the Sobel frame/line sequencer: FSM state codes,
// default counter width and synchroniser depth.
package sobel_ctrl_pkg;

   typedef logic [1:0] state_t;

   localparam state_t StIdle      = 2'd0;
   localparam state_t StWaitFrame = 2'd1;
   localparam state_t StActive    = 2'd2;
   localparam state_t StDone      = 2'd3;

   localparam int unsigned CNT_W_DEF  = 12;
   localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/sobel_frame_ctrl_sig_sync_edge.sv
// Synchroniser for one asynchronous level plus a registered edge stage; level,
// rise and fall come out of the same flop stage so they stay mutually aligned.
module sig_sync_edge
   import sobel_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_DEPTH-1:0] sync_q;
   logic                  synced;

   assign synced = sync_q[SYNC_DEPTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         level  <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_DEPTH-2:0], async_in};
         level  <= synced;
         rise   <= synced & ~level;
         fall   <= ~synced & level;
      end
   end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame/line sequencer for the Sobel pipeline: pixel/row counters, line-buffer
// strobe and window valid. Define SOBEL_FRAME_CTRL_CHK_EN to build the err_len checker.
module sobel_frame_ctrl
   import sobel_ctrl_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480,
   parameter int unsigned KSIZE = 3,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             vsync_i,
   input  logic             de_i,
   output logic             frame_start,
   output logic             frame_done,
   output logic             line_start,
   output logic             lb_wr_en,
   output logic             win_valid,
   output logic [CNT_W-1:0] col_cnt,
   output logic [CNT_W-1:0] row_cnt,
   output logic             busy,
   output logic             err_len
);

   localparam logic [CNT_W-1:0] ROW_END = CNT_W'(IMG_H);
   localparam logic [CNT_W-1:0] WIN_MIN = CNT_W'(KSIZE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   logic vs_level, vs_rise, vs_fall;
   logic de_level, de_rise, de_fall;
   logic unused_vs;

   sig_sync_edge u_vsync_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (vsync_i),
      .level    (vs_level),
      .rise     (vs_rise),
      .fall     (vs_fall)
   );

   sig_sync_edge u_de_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (de_i),
      .level    (de_level),
      .rise     (de_rise),
      .fall     (de_fall)
   );

   // Only the vsync rising edge carries timing information.
   assign unused_vs = vs_level ^ vs_fall;

   state_t           state_q, state_d;
   logic             frame_start_d, frame_done_d, line_start_d;
   logic             lb_wr_en_d, win_valid_d, busy_d;
   logic [CNT_W-1:0] col_d, row_d;

   always_comb begin
      state_d       = state_q;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;
      line_start_d  = 1'b0;
      lb_wr_en_d    = 1'b0;
      col_d         = col_cnt;
      row_d         = row_cnt;

      if (!enable) begin
         // Partial frame is dropped silently: no frame_done.
         state_d = StIdle;
         col_d   = '0;
         row_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StWaitFrame;
            end
            StWaitFrame: begin
               if (vs_rise) begin
                  state_d       = StActive;
                  frame_start_d = 1'b1;
                  col_d         = '0;
                  row_d         = '0;
               end
            end
            StActive: begin
               lb_wr_en_d   = de_level;
               line_start_d = de_rise;
               if (vs_rise) begin
                  // Early restart; a coincident de edge belongs to the new frame.
                  frame_start_d = 1'b1;
                  frame_done_d  = 1'b1;
                  col_d         = '0;
                  row_d         = '0;
               end else begin
                  if (de_rise) begin
                     col_d = '0;
                  end else if (de_level) begin
                     col_d = sat_inc(col_cnt);
                  end
                  if (de_fall) begin
                     row_d = sat_inc(row_cnt);
                     if (row_d >= ROW_END) begin
                        state_d      = StDone;
                        frame_done_d = 1'b1;
                     end
                  end
               end
            end
            StDone: begin
               state_d = StWaitFrame;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end

      win_valid_d = lb_wr_en_d && (row_d >= WIN_MIN) && (col_d >= WIN_MIN);
      busy_d      = (state_d == StActive);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         line_start  <= 1'b0;
         lb_wr_en    <= 1'b0;
         win_valid   <= 1'b0;
         col_cnt     <= '0;
         row_cnt     <= '0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_start <= frame_start_d;
         frame_done  <= frame_done_d;
         line_start  <= line_start_d;
         lb_wr_en    <= lb_wr_en_d;
         win_valid   <= win_valid_d;
         col_cnt     <= col_d;
         row_cnt     <= row_d;
         busy        <= busy_d;
      end
   end

`ifdef SOBEL_FRAME_CTRL_CHK_EN
   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);

   logic err_d;
   logic in_active;

   assign in_active = enable && (state_q == StActive);

   // Set wins over the clear so an early-vsync restart still reports.
   always_comb begin
      err_d = err_len;
      if (!enable || frame_start_d) begin
         err_d = 1'b0;
      end
      if (in_active && (vs_rise || (de_fall && (col_cnt != COL_LAST)))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_len <= 1'b0;
      end else begin
         err_len <= err_d;
      end
   end
`else
   assign err_len = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl: frame/line-level reference model
// compared every cycle, plus literal expectations for the headline scenarios.
module tb_sobel_frame_ctrl;

   localparam int unsigned IW = 8;
   localparam int unsigned IH = 4;
   localparam int unsigned KS = 3;
   localparam int unsigned CW = 12;
`ifdef SOBEL_FRAME_CTRL_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          vsync_i = 1'b0;
   logic          de_i = 1'b0;
   logic          frame_start, frame_done, line_start, lb_wr_en, win_valid, busy, err_len;
   logic [CW-1:0] col_cnt, row_cnt;

   sobel_frame_ctrl #(
      .IMG_W (IW),
      .IMG_H (IH),
      .KSIZE (KS),
      .CNT_W (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .vsync_i     (vsync_i),
      .de_i        (de_i),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .line_start  (line_start),
      .lb_wr_en    (lb_wr_en),
      .win_valid   (win_valid),
      .col_cnt     (col_cnt),
      .row_cnt     (row_cnt),
      .busy        (busy),
      .err_len     (err_len)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: raw inputs reach the outputs 3 edges after being sampled.
   localparam int M_IDLE = 0, M_WAIT = 1, M_ACT = 2, M_DONE = 3;
   bit [4:0] hv, hd;
   int  mode;
   int  pix;    // pixels in the current line including the one being output
   int  lines;  // completed lines in the current frame
   bit  e_fs, e_fd, e_ls, e_wr, e_wv, e_busy, e_err;
   int  cyc = 0;
   int  vs_edge = 0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            hv = '0; hd = '0; mode = M_IDLE; pix = 1; lines = 0;
            e_fs = 0; e_fd = 0; e_ls = 0; e_wr = 0; e_wv = 0; e_busy = 0; e_err = 0;
         end else begin
            bit d3, drise, dfall, vrise;
            cyc++;
            hv = {hv[3:0], vsync_i};
            hd = {hd[3:0], de_i};
            if (vsync_i && !hv[1]) vs_edge = cyc;
            d3    = hd[3];
            drise = hd[3] && !hd[4];
            dfall = !hd[3] && hd[4];
            vrise = hv[3] && !hv[4];
            e_fs = 0; e_fd = 0; e_ls = 0; e_wr = 0;
            if (!enable) begin
               mode = M_IDLE; pix = 1; lines = 0; e_err = 0;
            end else begin
               case (mode)
                  M_IDLE: mode = M_WAIT;
                  M_WAIT: if (vrise) begin
                     mode = M_ACT; e_fs = 1; pix = 1; lines = 0; e_err = 0;
                  end
                  M_DONE: mode = M_WAIT;
                  default: begin
                     e_wr = d3;
                     e_ls = drise;
                     if (vrise) begin
                        e_fs = 1; e_fd = 1; pix = 1; lines = 0;
                        if (CHK) e_err = 1;
                     end else begin
                        if (drise) pix = 1;
                        else if (d3 && pix < (1 << CW)) pix++;
                        if (dfall) begin
                           if (CHK && pix != IW) e_err = 1;
                           lines++;
                           if (lines == IH) begin
                              mode = M_DONE; e_fd = 1;
                           end
                        end
                     end
                  end
               endcase
            end
            e_wv   = e_wr && lines >= KS - 1 && pix - 1 >= KS - 1;
            e_busy = (mode == M_ACT);
         end
      end
   end

   // Per-cycle compare and event counters.
   int wr_cnt, ls_cnt, wv_cnt, fd_cnt, fs_cnt, both_cnt, both_row, both_err, fs_edge;

   task automatic clear_counts();
      wr_cnt = 0; ls_cnt = 0; wv_cnt = 0; fd_cnt = 0; fs_cnt = 0; both_cnt = 0;
   endtask

   initial begin
      clear_counts();
      forever begin
         logic [6:0] act, exp;
         @(negedge clk);
         act = {frame_start, frame_done, line_start, lb_wr_en, win_valid, busy, err_len};
         exp = {e_fs, e_fd, e_ls, e_wr, e_wv, e_busy, e_err};
         vectors++;
         if (act !== exp || int'(col_cnt) != pix - 1 || int'(row_cnt) != lines) begin
            miscompares++;
            $display("FAIL model cycle %0d: fs/fd/ls/wr/wv/busy/err=%b col=%0d row=%0d, expected %b col=%0d row=%0d",
                     cyc, act, col_cnt, row_cnt, exp, pix - 1, lines);
         end
         if (lb_wr_en) wr_cnt++;
         if (line_start) ls_cnt++;
         if (win_valid) wv_cnt++;
         if (frame_done) fd_cnt++;
         if (frame_start) begin
            fs_cnt++;
            fs_edge = cyc;
         end
         if (frame_start && frame_done) begin
            both_cnt++;
            both_row = int'(row_cnt);
            both_err = int'(err_len);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int outs_or();
      return int'(frame_start | frame_done | line_start | lb_wr_en | win_valid | busy |
                  err_len | (|col_cnt) | (|row_cnt));
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic vpulse();
      vsync_i = 1'b1;
      tick(2);
      vsync_i = 1'b0;
   endtask

   task automatic line(input int npix, input int gap);
      de_i = 1'b1;
      tick(npix);
      de_i = 1'b0;
      tick(gap);
   endtask

   initial begin
      // Reset, then enabled with no vsync.
      tick(3);
      check("reset_outs", outs_or(), 0);
      rst_n = 1'b1;
      tick(2);
      enable = 1'b1;
      tick(10);
      check("no_vsync_outs", outs_or(), 0);
      check("no_vsync_busy", int'(busy), 0);

      // Nominal 8x4 frame.
      clear_counts();
      vpulse();
      tick(4);
      check("busy_in_frame", int'(busy), 1);
      repeat (4) line(8, 4);
      tick(10);
      check("fs_latency", fs_edge - vs_edge, 3);
      check("wr_strobes", wr_cnt, 32);
      check("line_starts", ls_cnt, 4);
      check("win_valids", wv_cnt, 12);
      check("frame_dones", fd_cnt, 1);
      check("frame_starts", fs_cnt, 1);
      check("err_clean", int'(err_len), 0);
      check("busy_after_done", int'(busy), 0);

      // Early vsync after 2 lines, then a full restarted frame.
      clear_counts();
      vpulse();
      tick(4);
      repeat (2) line(8, 4);
      vpulse();
      tick(6);
      repeat (4) line(8, 4);
      tick(10);
      check("early_both_pulse", both_cnt, 1);
      check("early_row", both_row, 0);
      check("early_err", both_err, int'(CHK));
      check("early_fd_total", fd_cnt, 2);
      check("early_wr_total", wr_cnt, 48);

      // Short line sets err_len; next frame_start clears it.
      vpulse();
      tick(4);
      check("err_pre_short", int'(err_len), 0);
      line(7, 4);
      tick(1);
      check("err_short_line", int'(err_len), int'(CHK));
      repeat (3) line(8, 4);
      tick(6);
      check("err_held_after_done", int'(err_len), int'(CHK));
      vpulse();
      tick(5);
      check("err_cleared", int'(err_len), 0);

      // Enable dropped mid-line 2 of that frame.
      clear_counts();
      line(8, 4);
      de_i = 1'b1;
      tick(5);
      enable = 1'b0;
      tick(1);
      check("en_drop_outs", outs_or(), 0);
      tick(3);
      de_i = 1'b0;
      tick(10);
      check("en_drop_no_fd", fd_cnt, 0);
      enable = 1'b1;
      tick(2);
      clear_counts();
      repeat (2) line(8, 4);
      check("de_ignored_wait", wr_cnt, 0);

      // Asynchronous reset mid-frame.
      vpulse();
      tick(4);
      line(8, 4);
      de_i = 1'b1;
      tick(3);
      #2 rst_n = 1'b0;
      #1 check("async_rst_outs", outs_or(), 0);
      tick(2);
      rst_n = 1'b1;
      clear_counts();
      tick(3);
      de_i = 1'b0;
      tick(4);
      repeat (2) line(8, 4);
      check("de_ignored_rst", wr_cnt, 0);
      vpulse();
      tick(4);
      repeat (4) line(8, 4);
      tick(10);
      check("post_rst_wr", wr_cnt, 32);
      check("post_rst_fd", fd_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame/line sequencer for the Sobel pipeline. Synchronises raw camera vsync/de, detects their edges and runs a frame state machine that drives the pixel/row counters, line-buffer write enable and 3x3 kernel-window valid. Sits between the sensor interface and the line buffers / Sobel kernel, and is their only source of timing.

## Interface
- IMG_W, 640: active pixels per line.
- IMG_H, 480: active lines per frame.
- KSIZE, 3: kernel size; window valid once KSIZE-1 rows and columns are buffered.
- CNT_W, 12: counter width; must satisfy 2^CNT_W > max(IMG_W, IMG_H).
- clk  in  1  pixel clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  controller run enable; level, already synchronous to clk.
- vsync_i  in  1  raw frame sync, asynchronous, active-high.
- de_i  in  1  raw data-enable, asynchronous, high during active pixels.
- frame_start  out  1  one-cycle pulse at frame begin.
- frame_done  out  1  one-cycle pulse at frame end.
- line_start  out  1  one-cycle pulse at the first pixel of each line.
- lb_wr_en  out  1  line-buffer write strobe, one per active pixel.
- win_valid  out  1  kernel window complete for the current pixel.
- col_cnt  out  CNT_W  pixel index within the line, 0-based.
- row_cnt  out  CNT_W  line index within the frame, 0-based.
- busy  out  1  high in ACTIVE.
- err_len  out  1  sticky geometry error; see Configuration.

## Operation
- vsync_i and de_i each pass a 2-flop synchroniser, then a 1-flop edge stage. This yields rise and fall pulses.
- States:
  - IDLE: entered on reset or when enable is low. All outputs are 0.
  - WAIT_FRAME: waits for a vsync rise.
  - ACTIVE: counts pixels and lines.
  - DONE: lasts one cycle, then goes to WAIT_FRAME.
- IDLE -> WAIT_FRAME when enable=1.
- WAIT_FRAME -> ACTIVE on vsync rise. Pulse frame_start, row_cnt=0, col_cnt=0.
- In ACTIVE, while synchronised de is high:
  - lb_wr_en=1.
  - col_cnt increments after each pixel and saturates at 2^CNT_W-1.
  - The de rise pulses line_start and reloads col_cnt to 0 for that pixel.
- The de fall in ACTIVE increments row_cnt.
- ACTIVE -> DONE when row_cnt reaches IMG_H. Pulse frame_done in DONE.
- Early vsync rise in ACTIVE (fewer than IMG_H lines):
  - Pulse frame_done and frame_start in the same cycle.
  - Restart counters and stay in ACTIVE.
- de activity outside ACTIVE is ignored: no strobes, counters hold.
- win_valid = lb_wr_en && row_cnt >= KSIZE-1 && col_cnt >= KSIZE-1.
- enable falling in any state: next state is IDLE, and all outputs go to 0 on the following edge. Any partial frame is discarded with no frame_done.
- Counters compare in CNT_W unsigned arithmetic. No wrap is allowed, because counters saturate.

## Timing
- Reset values: every output is 0, state is IDLE, and synchroniser/edge flops are 0.
- Every output is registered.
- Latency from the clk edge that first samples a de_i/vsync_i change to the corresponding output change: 3 cycles. Downstream pixel data must be delayed by 3 cycles to align with lb_wr_en.
- frame_done pulses in the cycle after the last de fall that completes line IMG_H.
- Minimum de low gap: 2 cycles. A gap of 1 cycle is not guaranteed to register as a line end.
- When a de rise and a vsync rise coincide in ACTIVE, vsync wins. The frame restarts, and the pixel counts as col 0 of row 0.

## Configuration
- SOBEL_FRAME_CTRL_CHK_EN defined:
  - err_len is set in either of two cases. The first is a line ending with col_cnt+1 != IMG_W. The second is a frame ending by an early vsync.
  - err_len is sticky and clears only on frame_start or reset.
- SOBEL_FRAME_CTRL_CHK_EN undefined: the err_len port remains and is tied to 0, and no checking logic is built.

## Structure
- Package sobel_ctrl_pkg holds:
  - the state enum (IDLE, WAIT_FRAME, ACTIVE, DONE);
  - the default CNT_W;
  - the synchroniser depth constant, value 2.
- One sub-module, sig_sync_edge: 2-flop synchroniser plus rise/fall pulse. It is instantiated twice, once for vsync and once for de.

## Test plan
Benches use IMG_W=8, IMG_H=4, KSIZE=3.
- Reset, then enable=1 with no vsync -> all outputs 0, busy=0.
- vsync pulse, then 4 lines of 8 de cycles with 4-cycle gaps:
  - frame_start appears 3 cycles after the vsync rise.
  - 32 lb_wr_en strobes and 4 line_start pulses.
  - win_valid count = 2 rows x 6 cols = 12.
  - A single frame_done after line 4.
- Early vsync after 2 lines -> frame_done and frame_start in the same cycle, row_cnt=0. With CHK_EN, err_len=1.
- Line of 7 pixels with CHK_EN -> err_len=1 at that line end, cleared at the next frame_start.
- enable dropped mid-line 2 -> IDLE next cycle, outputs 0, no frame_done.
- rst_n asserted mid-frame asynchronously -> all outputs 0 immediately. After release, de is ignored until the next vsync rise.
